htif_host: RTL and testbench

HTIF_HOST -- requirements
Module: htif_host

---
 rtl/htif_host.sv | 111 +++++++++++
 tb/tb_htif_host.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/htif_host.sv
// htif_host: turns word read/write requests into the 'a'/'w'/'r' byte protocol toward a target.
// Optional address cache (skip 'a' phase on sequential access) enabled by defining HTIF_HOST_ADDR_CACHE_EN.
module htif_host (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_address,
  input  logic [31:0] req_data,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [7:0]  rx_data
);
  // R0..R3 sit on a 4-aligned encoding so the low two state bits index the captured byte
  typedef enum logic [3:0] {
    IDLE = 4'd0, ACMD = 4'd1, A0 = 4'd2, A1 = 4'd3, A2 = 4'd4, A3 = 4'd5, OP = 4'd6,
    D0 = 4'd7, D1 = 4'd8, D2 = 4'd9, D3 = 4'd10, RESP = 4'd11,
    R0 = 4'd12, R1 = 4'd13, R2 = 4'd14, R3 = 4'd15
  } state_t;
  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        skip;
  logic        accept;
  logic        op_done;
  assign accept  = req_valid && req_ready;
  assign op_done = state_q == OP && tx_ready;
`ifdef HTIF_HOST_ADDR_CACHE_EN
  logic        cache_vld_q, cache_vld_d;
  logic [31:0] next_addr_q, next_addr_d;
  assign skip = cache_vld_q && req_address == next_addr_q;
  always_comb begin
    cache_vld_d = cache_vld_q || op_done;
    next_addr_d = op_done ? addr_q + 32'd4 : next_addr_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cache_vld_q <= 1'b0;
      next_addr_q <= '0;
    end else begin
      cache_vld_q <= cache_vld_d;
      next_addr_q <= next_addr_d;
    end
  end
`else
  assign skip = 1'b0;
`endif
  assign req_ready = state_q == IDLE;
  assign tx_valid  = state_q inside {ACMD, A0, A1, A2, A3, OP, D0, D1, D2, D3};
  assign rx_ready  = state_q inside {R0, R1, R2, R3};
  assign res_valid = state_q == RESP;
  assign res_data  = rdata_q;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:           if (req_valid) state_d = skip ? OP : ACMD;
      OP:             if (tx_ready) state_d = write_q ? D0 : R0;
      D3:             if (tx_ready) state_d = IDLE;
      R0, R1, R2:     if (rx_valid) state_d = state_t'(state_q + 4'd1);
      R3:             if (rx_valid) state_d = RESP;
      RESP:           state_d = IDLE;
      default:        if (tx_ready) state_d = state_t'(state_q + 4'd1);
    endcase
  end
  always_comb begin
    write_d = accept ? req_write : write_q;
    addr_d  = accept ? req_address : addr_q;
    wdata_d = accept ? req_data : wdata_q;
    rdata_d = rdata_q;
    if (rx_valid && rx_ready) rdata_d[8*state_q[1:0] +: 8] = rx_data;
  end
  always_comb begin
    tx_data = 8'h00;
    case (state_q)
      ACMD:    tx_data = 8'h61;
      A0:      tx_data = addr_q[7:0];
      A1:      tx_data = addr_q[15:8];
      A2:      tx_data = addr_q[23:16];
      A3:      tx_data = addr_q[31:24];
      OP:      tx_data = write_q ? 8'h77 : 8'h72;
      D0:      tx_data = wdata_q[7:0];
      D1:      tx_data = wdata_q[15:8];
      D2:      tx_data = wdata_q[23:16];
      D3:      tx_data = wdata_q[31:24];
      default: tx_data = 8'h00;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
endmodule

// File: tb/tb_htif_host.sv
// tb_htif_host: directed checks of htif_host byte sequences, responses, stalls, reset abort and address cache.
module tb_htif_host;
  logic        clk = 0;
  logic        reset = 1;
  logic        req_valid = 0, req_ready, req_write = 0;
  logic [31:0] req_address = 0, req_data = 0;
  logic        res_valid;
  logic [31:0] res_data;
  logic        tx_valid, tx_ready = 0;
  logic [7:0]  tx_data;
  logic        rx_valid = 0, rx_ready;
  logic [7:0]  rx_data = 0;
  int          checks = 0, errors = 0;
  logic [7:0]  txq[$];
  int          nres, stab_err, rxr_err;
  logic [31:0] rdat;
  htif_host dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_address(req_address), .req_data(req_data),
    .res_valid(res_valid), .res_data(res_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data)
  );
  always #5 clk = ~clk;
  function automatic logic [95:0] packq();
    logic [95:0] v = '0;
    foreach (txq[i]) v = {v[87:0], txq[i]};
    return v;
  endfunction
  // Drives one request and plays the target: collects tx bytes, feeds rw little-endian on rx.
  task automatic run_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] rw, input bit stall);
    int rx_idx = 0;
    logic prev_hold = 0;
    logic [7:0] prev_b = 0;
    bit done = 0;
    txq.delete();
    nres = 0; rdat = 0; stab_err = 0; rxr_err = 0;
    for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
    req_valid = 1; req_write = w; req_address = a; req_data = d;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      req_valid = 0;
      if (req_ready) begin
        done = 1;
        break;
      end
      if (prev_hold && tx_data !== prev_b) stab_err++;
      tx_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      rx_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      rx_data  = rw[8*rx_idx +: 8];
      if (rx_ready && (w || tx_valid)) rxr_err++;
      if (tx_valid && tx_ready) txq.push_back(tx_data);
      if (rx_valid && rx_ready && rx_idx < 3) rx_idx++;
      if (res_valid) begin
        nres++;
        rdat = res_data;
      end
      prev_hold = tx_valid && !tx_ready;
      prev_b = tx_data;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL timeout: request addr=%h never returned to idle", a);
    end
    tx_ready = 0; rx_valid = 0;
  endtask
  task automatic test_reset();
    reset = 1;
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    checks += 6;
    if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset tx_valid got %b want 0", tx_valid); end
    if (rx_ready !== 1'b0) begin errors++; $display("FAIL reset rx_ready got %b want 0", rx_ready); end
    if (res_valid !== 1'b0) begin errors++; $display("FAIL reset res_valid got %b want 0", res_valid); end
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset req_ready got %b want 1", req_ready); end
    if (tx_data !== 8'h00) begin errors++; $display("FAIL reset tx_data got %h want 00", tx_data); end
    if (res_data !== 32'h0) begin errors++; $display("FAIL reset res_data got %h want 0", res_data); end
  endtask
  task automatic test_read();
    run_req(0, 32'h0000_1000, 0, 32'h1234_5678, 0);
    checks += 5;
    if (txq.size() != 6) begin errors++; $display("FAIL read tx count got %0d want 6", txq.size()); end
    if (packq() !== 96'h61_00_10_00_00_72) begin errors++; $display("FAIL read tx bytes got %h want 610010000072", packq()); end
    if (nres != 1) begin errors++; $display("FAIL read res_valid pulses got %0d want 1", nres); end
    if (rdat !== 32'h1234_5678) begin errors++; $display("FAIL read res_data got %h want 12345678", rdat); end
    if (rxr_err != 0) begin errors++; $display("FAIL read rx_ready misplaced got %0d want 0", rxr_err); end
  endtask
  task automatic test_write();
    run_req(1, 32'h0000_0020, 32'hDEAD_BEEF, 0, 0);
    checks += 5;
    if (txq.size() != 10) begin errors++; $display("FAIL write tx count got %0d want 10", txq.size()); end
    if (packq() !== 96'h61_20_00_00_00_77_EF_BE_AD_DE) begin errors++; $display("FAIL write tx bytes got %h want 61200000007 7EFBEADDE", packq()); end
    if (nres != 0) begin errors++; $display("FAIL write res_valid pulses got %0d want 0", nres); end
    if (req_ready !== 1'b1) begin errors++; $display("FAIL write req_ready got %b want 1", req_ready); end
    if (rxr_err != 0) begin errors++; $display("FAIL write rx_ready got %0d want 0", rxr_err); end
  endtask
  task automatic test_cache();
    run_req(0, 32'h0000_0024, 0, 32'hCAFE_F00D, 0);
    checks += 2;
`ifdef HTIF_HOST_ADDR_CACHE_EN
    if (packq() !== 96'h72 || txq.size() != 1) begin errors++; $display("FAIL cache seq read got %h (%0d bytes) want 72", packq(), txq.size()); end
`else
    if (packq() !== 96'h61_24_00_00_00_72 || txq.size() != 6) begin errors++; $display("FAIL cache seq read got %h (%0d bytes) want 612400000072", packq(), txq.size()); end
`endif
    if (rdat !== 32'hCAFE_F00D) begin errors++; $display("FAIL cache seq data got %h want cafef00d", rdat); end
    run_req(0, 32'h0000_0040, 0, 32'h0102_0304, 0);
    checks += 2;
    if (packq() !== 96'h61_40_00_00_00_72 || txq.size() != 6) begin errors++; $display("FAIL cache miss read got %h want 614000000072", packq()); end
    if (rdat !== 32'h0102_0304) begin errors++; $display("FAIL cache miss data got %h want 01020304", rdat); end
  endtask
  task automatic test_wrap();
    run_req(0, 32'hFFFF_FFFC, 0, 32'h89AB_CDEF, 0);
    checks += 2;
    if (packq() !== 96'h61_FC_FF_FF_FF_72 || txq.size() != 6) begin errors++; $display("FAIL wrap first got %h want 61fcffffff72", packq()); end
    if (rdat !== 32'h89AB_CDEF) begin errors++; $display("FAIL wrap first data got %h want 89abcdef", rdat); end
    run_req(0, 32'h0000_0000, 0, 32'h5555_AAAA, 0);
    checks += 2;
`ifdef HTIF_HOST_ADDR_CACHE_EN
    if (packq() !== 96'h72 || txq.size() != 1) begin errors++; $display("FAIL wrap second got %h want 72", packq()); end
`else
    if (packq() !== 96'h61_00_00_00_00_72 || txq.size() != 6) begin errors++; $display("FAIL wrap second got %h want 610000000072", packq()); end
`endif
    if (rdat !== 32'h5555_AAAA) begin errors++; $display("FAIL wrap second data got %h want 5555aaaa", rdat); end
  endtask
  task automatic test_stall();
    run_req(0, 32'h0000_1000, 0, 32'hA5C3_0F96, 1);
    checks += 5;
    if (packq() !== 96'h61_00_10_00_00_72 || txq.size() != 6) begin errors++; $display("FAIL stall read bytes got %h want 610010000072", packq()); end
    if (rdat !== 32'hA5C3_0F96) begin errors++; $display("FAIL stall read data got %h want a5c30f96", rdat); end
    if (nres != 1) begin errors++; $display("FAIL stall read pulses got %0d want 1", nres); end
    if (stab_err != 0) begin errors++; $display("FAIL stall tx_data unstable got %0d want 0", stab_err); end
    if (rxr_err != 0) begin errors++; $display("FAIL stall rx_ready misplaced got %0d want 0", rxr_err); end
    run_req(1, 32'h0000_0020, 32'h1122_3344, 0, 1);
    checks += 3;
    if (packq() !== 96'h61_20_00_00_00_77_44_33_22_11 || txq.size() != 10) begin errors++; $display("FAIL stall write bytes got %h", packq()); end
    if (stab_err != 0) begin errors++; $display("FAIL stall write unstable got %0d want 0", stab_err); end
    if (rxr_err != 0 || nres != 0) begin errors++; $display("FAIL stall write rx_ready/res got %0d/%0d want 0/0", rxr_err, nres); end
  endtask
  task automatic test_reset_mid();
    @(negedge clk);
    tx_ready = 1; rx_valid = 0;
    req_valid = 1; req_write = 1; req_address = 32'h20; req_data = 32'hDEAD_BEEF;
    repeat (8) begin
      @(negedge clk);
      req_valid = 0;
    end
    checks++;
    if (tx_data !== 8'hBE || tx_valid !== 1'b1) begin errors++; $display("FAIL abort D1 byte got %h/%b want be/1", tx_data, tx_valid); end
    reset = 1;
    @(negedge clk);
    reset = 0; tx_ready = 0;
    checks += 2;
    if (tx_valid !== 1'b0 || res_valid !== 1'b0) begin errors++; $display("FAIL abort tx_valid/res_valid got %b/%b want 0/0", tx_valid, res_valid); end
    if (req_ready !== 1'b1) begin errors++; $display("FAIL abort req_ready got %b want 1", req_ready); end
    run_req(0, 32'h0000_0024, 0, 32'h0BAD_F00D, 0);
    checks += 2;
    if (packq() !== 96'h61_24_00_00_00_72 || txq.size() != 6) begin errors++; $display("FAIL abort cache cleared got %h want 612400000072", packq()); end
    if (rdat !== 32'h0BAD_F00D) begin errors++; $display("FAIL abort read data got %h want 0badf00d", rdat); end
    run_req(0, 32'h0000_0020, 0, 32'h7777_0001, 0);
    checks++;
`ifdef HTIF_HOST_ADDR_CACHE_EN
    if (packq() !== 96'h61_20_00_00_00_72 || txq.size() != 6) begin errors++; $display("FAIL abort same addr got %h want 612000000072", packq()); end
`else
    if (packq() !== 96'h61_20_00_00_00_72 || txq.size() != 6) begin errors++; $display("FAIL abort same addr got %h want 612000000072", packq()); end
`endif
  endtask
  initial begin
    test_reset();
    test_read();
    test_write();
    test_cache();
    test_wrap();
    test_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
